serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first add of x+y+cin over WIDTH cycles with one full adder.
// Optional signed-overflow output enabled by macro SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic w_s;
  logic w_c;

  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Partial sum builds in r_acc; r_sum/r_cout only move when a result is
  // complete, so the visible result holds through IDLE and SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= x;
            r_b     <= y;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_acc   <= {w_s, r_acc[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is the stored carry on the last bit.
            r_ovf   <= r_carry ^ w_c;
`endif
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_sum   <= r_acc;
          r_cout  <= r_carry;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with a result scoreboard.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input string tag);
    exp_t r;
    logic [W:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    r.tag  = tag;
    return r;
  endfunction

  task automatic check_result();
    exp_t e;
    chk("sb_has_entry", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, "_sum"}, 32'(sum), 32'(e.sum));
      chk({e.tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      $display("txn %s: sum=%b cout=%b", e.tag, sum, cout);
    end
  endtask

  // Called #1 after an edge; start is sampled on the next edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input string tag);
    int n;
    bit seen;
    x = a; y = b; cin = c; start = 1'b1;
    q.push_back(model(a, b, c, tag));
    @(posedge clk); #1;
    start = 1'b0;
    x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("ready_busy_excl", 32'(ready & busy), 32'd0);
      if (done) seen = 1;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    if (seen) check_result();
    else q.delete();
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum),   32'd0);
    chk("rst_cout",  32'(cout),  32'd0);
    rst = 1'b0;

    // Reset during the second SHIFT cycle abandons the operation
    x = 4'b0101; y = 4'b0011; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("rstmid_no_done", 32'(dn), 32'd0);
    chk("rstmid_sum",   32'(sum),   32'd0);
    chk("rstmid_cout",  32'(cout),  32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    chk("rstmid_busy",  32'(busy),  32'd0);
    $display("txn rst_mid: sum=%b cout=%b ready=%b", sum, cout, ready);

    run_op(4'b0101, 4'b0011, 1'b0, "basic");

    // Result holds through idle cycles regardless of inputs
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom);
      @(posedge clk); #1;
      chk("hold_sum",  32'(sum),  32'b1000);
      chk("hold_cout", 32'(cout), 32'd0);
      chk("hold_done", 32'(done), 32'd0);
    end
    $display("txn hold: sum=%b cout=%b", sum, cout);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_clears_sum", 32'(sum), 32'd0);
    $display("txn rst_clear: sum=%b", sum);

    run_op(4'b1111, 4'b1111, 1'b1, "carry_all");
    run_op(4'b1111, 4'b0000, 1'b1, "carry_wrap");

    // start held high: extra starts ignored until IDLE, then accepted
    x = 4'b0001; y = 4'b0001; cin = 1'b0; start = 1'b1;
    q.push_back(model(4'b0001, 4'b0001, 1'b0, "ign1"));
    @(posedge clk); #1;
    x = 4'b1000;
    dn = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 6) begin
        start = 1'b0;
        q.push_back(model(4'b1000, 4'b0001, 1'b0, "ign2"));
      end
      if (done) begin
        dn++;
        chk("ign_done_edge", 32'(e), (dn == 1) ? 32'd5 : 32'd11);
        check_result();
      end
    end
    chk("ign_done_count", 32'(dn), 32'd2);
    q.delete();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(W'(a), W'(b), 1'(c), "exh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
